xor_lane_pipe: RTL and testbench
================================

XOR_LANE_PIPE -- requirements
Module: xor_lane_pipe

Interface
REQ-001 Parameter WIDTH, default 8, bits per lane (min 1).
REQ-002 Parameter LANES, default 4, independent lanes per beat (min 1).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  input beat present.
REQ-006 Port in_ready  output  1  block can accept a beat this cycle.
REQ-007 Port in_a  input  WIDTH*LANES  operand A, lane k at bits [k*WIDTH +: WIDTH].
REQ-008 Port in_b  input  WIDTH*LANES  operand B, same packing.
REQ-009 Port in_mode  input  2  0 XOR, 1 XNOR, 2 per-lane parity, 3 bypass A.
REQ-010 Port out_valid  output  1  result beat present.
REQ-011 Port out_ready  input  1  downstream accepts result.
REQ-012 Port out_data  output  WIDTH*LANES  result, same packing.
REQ-013 Port out_par  output  LANES  even parity of each result lane.
REQ-014 Port op_cnt  output  16  completed-beat count (see Configuration).

Function
REQ-015 Transfer occurs on a port when valid and ready are both high at a rising clk edge.
REQ-016 Two register stages: S1 captures in_a, in_b, in_mode; S2 holds computed out_data and out_par.
REQ-017 Latency: accepted beat appears on out_valid exactly 2 cycles later when out_ready held high.
REQ-018 Mode 0: lane = A ^ B; mode 1: lane = ~(A ^ B); mode 2: lane bit 0 = reduction XOR of (A ^ B), upper bits 0; mode 3: lane = A.
REQ-019 out_par[k] = reduction XOR of out_data lane k, registered with out_data.
REQ-020 Mode is captured per beat; beats of different modes may be back-to-back without bubbles.
REQ-021 Each stage loads when empty or when its own content is leaving the same cycle.
REQ-022 in_ready = !S1_full || (S1 moving to S2 this cycle); combinational from out_ready permitted.
REQ-023 With out_ready high continuously, throughput is one beat per cycle.
REQ-024 out_ready low with both stages full: in_ready low, out_data/out_valid/out_par held stable until accepted.
REQ-025 out_data and out_par shall not change while out_valid high and out_ready low.
REQ-026 No beat is dropped or duplicated; output order equals input order.
REQ-027 Simultaneous output accept and input accept with both stages full: all stages advance, no bubble.
REQ-028 in_a/in_b/in_mode ignored when in_valid low.

Reset
REQ-029 rst_n low asynchronously clears S1/S2 valid flags: out_valid 0, in_ready 0 while rst_n low.
REQ-030 During reset out_data = 0, out_par = 0, op_cnt = 0.
REQ-031 Beats in flight when reset asserts are discarded; first edge after rst_n rises may accept a beat (in_ready 1).

Configuration
REQ-032 Macro XOR_LANE_PIPE_STATS_EN: when defined, op_cnt increments by 1 on each output transfer, saturates at 16'hFFFF.
REQ-033 When XOR_LANE_PIPE_STATS_EN is undefined, op_cnt is constant 0 and no counter register exists.

Verification (WIDTH=8, LANES=4)
REQ-034 Mode 0, A=32'hFF00_A5_3C, B=32'h0F0F_5A_3C, out_ready=1 -> 2 cycles later out_data=32'hF00F_FF00, out_par=4'b0000.
REQ-035 Sweep per lane all four {0,1} bit pairs in modes 0/1 -> lane results equal XOR / XNOR truth table; mode 2 A=32'h01030700,B=0 -> out_data=32'h01000100.
REQ-036 Ten back-to-back beats, modes cycling 0..3, out_ready=1 -> ten results in order on ten consecutive cycles, in_ready never low.
REQ-037 out_ready=0 for 5 cycles while feeding -> in_ready low after 2 accepted beats, out_data stable; release -> both beats emitted in order, none lost.
REQ-038 rst_n pulsed low mid-stream with 2 beats in flight -> out_valid 0 immediately (asynchronous), no stale beat after release, op_cnt 0.
REQ-039 With XOR_LANE_PIPE_STATS_EN, 70000 transfers -> op_cnt 16'hFFFF; without macro -> op_cnt 0 throughout.

Source files
------------

// File: rtl/xor_lane_pipe.sv
// xor_lane_pipe
// Two-stage valid/ready pipeline that combines LANES independent WIDTH-bit lanes of two
// operands. Stage 1 registers the operands and the per-beat mode. Stage 2 registers the
// computed result together with the even parity of every result lane.
//
// Modes (captured per beat):
//   0: A ^ B    1: ~(A ^ B)    2: bit 0 = reduction XOR of (A ^ B), upper bits 0    3: A
//
// Ports:
//   clk        single clock, rising-edge
//   rst_n      asynchronous active-low reset; clears both stages and the counter
//   in_valid   input beat present
//   in_ready   block can accept a beat this cycle
//   in_a       operand A, lane k at bits [k*WIDTH +: WIDTH]
//   in_b       operand B, same packing
//   in_mode    operation select
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   out_data   result, same packing
//   out_par    even parity of each result lane
//   op_cnt     completed-beat count
//
// Build option: define XOR_LANE_PIPE_STATS_EN to include a saturating 16-bit counter of
// output transfers on op_cnt. Without it op_cnt is tied to zero and no counter exists.
module xor_lane_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*LANES-1:0]   in_a,
    input  logic [WIDTH*LANES-1:0]   in_b,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*LANES-1:0]   out_data,
    output logic [LANES-1:0]         out_par,
    output logic [15:0]              op_cnt
);

    localparam int unsigned DW = WIDTH * LANES;

    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_a_q, s1_a_d;
    logic [DW-1:0] s1_b_q, s1_b_d;
    logic [1:0]    s1_mode_q, s1_mode_d;

    logic             s2_valid_q, s2_valid_d;
    logic [DW-1:0]    s2_data_q, s2_data_d;
    logic [LANES-1:0] s2_par_q, s2_par_d;

    logic             out_fire;
    logic             s1_move;
    logic             in_fire;
    logic [DW-1:0]    res_data;
    logic [LANES-1:0] res_par;
    logic [WIDTH-1:0] lane_x;
    logic [WIDTH-1:0] lane_r;

    // Handshake: each stage loads when empty or when its content leaves this cycle.
    // in_ready is held low while reset is asserted even though the flags are already clear.
    always_comb begin
        out_fire = s2_valid_q && out_ready;
        s1_move  = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready = rst_n && (!s1_valid_q || s1_move);
        in_fire  = in_valid && in_ready;
    end

    // Lane datapath operating on the stage-1 contents.
    always_comb begin
        res_data = '0;
        res_par  = '0;
        lane_x   = '0;
        lane_r   = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_x = s1_a_q[k*WIDTH +: WIDTH] ^ s1_b_q[k*WIDTH +: WIDTH];
            unique case (s1_mode_q)
                2'd0: lane_r = lane_x;
                2'd1: lane_r = ~lane_x;
                2'd2: begin
                    lane_r    = '0;
                    lane_r[0] = ^lane_x;
                end
                default: lane_r = s1_a_q[k*WIDTH +: WIDTH];
            endcase
            res_data[k*WIDTH +: WIDTH] = lane_r;
            res_par[k]                 = ^lane_r;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_mode_d  = in_mode;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_par_d   = s2_par_q;
        if (s1_move) begin
            s2_valid_d = 1'b1;
            s2_data_d  = res_data;
            s2_par_d   = res_par;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= 2'd0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_par_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_par_q   <= s2_par_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_par   = s2_par_q;

`ifdef XOR_LANE_PIPE_STATS_EN
    logic [15:0] op_cnt_q, op_cnt_d;

    // Saturating count of output transfers.
    always_comb begin
        op_cnt_d = op_cnt_q;
        if (out_fire && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= 16'd0;
        end else begin
            op_cnt_q <= op_cnt_d;
        end
    end

    assign op_cnt = op_cnt_q;
`else
    assign op_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_xor_lane_pipe.sv
// Self-checking bench for xor_lane_pipe (WIDTH=8, LANES=4). A queue-based reference model
// predicts every output beat; a monitor compares on each falling edge. Directed tests pin
// literal results, latency, throughput, backpressure, reset and the op_cnt behaviour.
module tb_xor_lane_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned DW = W * L;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [L-1:0]  out_par;
    logic [15:0]   op_cnt;

    int checks = 0;
    int fails  = 0;

    logic [DW+L-1:0] exp_q[$];
    int              exp_cnt = 0;
    int              cyc = 0;
    bit              rec_en = 0;
    int              rec_n = 0;
    int              rec_gaps = 0;
    int              last_fire_cyc = 0;

    xor_lane_pipe #(
        .WIDTH(W),
        .LANES(L)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_par  (out_par),
        .op_cnt   (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: result {par, data} of one beat, computed lane by lane from the mode rules.
    function automatic logic [DW+L-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [1:0] m);
        logic [DW-1:0] d;
        logic [L-1:0]  p;
        logic [W-1:0]  la, lb, r;
        d = '0;
        p = '0;
        for (int k = 0; k < L; k++) begin
            la = a[k*W +: W];
            lb = b[k*W +: W];
            case (m)
                2'd0:    r = la ^ lb;
                2'd1:    r = ~(la ^ lb);
                2'd2:    r = W'($countones(la ^ lb) % 2);
                default: r = la;
            endcase
            d[k*W +: W] = r;
            p[k]        = ($countones(r) % 2) == 1;
        end
        return {p, d};
    endfunction

    // Monitor: sample on the falling edge, i.e. the state that the next rising edge acts on.
    initial begin
        logic            stall_prev;
        logic [DW-1:0]   prev_data;
        logic [L-1:0]    prev_par;
        logic [DW+L-1:0] e;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_par   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                exp_cnt    = 0;
                stall_prev = 1'b0;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd0);
                chk("rst_out_data", 64'(out_data), 64'd0);
                chk("rst_out_par", 64'(out_par), 64'd0);
                chk("rst_op_cnt", 64'(op_cnt), 64'd0);
            end else begin
                chk("op_cnt", 64'(op_cnt), 64'(exp_cnt));
                if (stall_prev) begin
                    chk("hold_out_valid", 64'(out_valid), 64'd1);
                    chk("hold_out_data", 64'(out_data), 64'(prev_data));
                    chk("hold_out_par", 64'(out_par), 64'(prev_par));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_beat actual=%0h required=none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 64'(out_data), 64'(e[DW-1:0]));
                        chk("beat_par", 64'(out_par), 64'(e[DW+L-1:DW]));
                    end
`ifdef XOR_LANE_PIPE_STATS_EN
                    if (exp_cnt < 16'hFFFF) exp_cnt++;
`endif
                    if (rec_en) begin
                        if (rec_n > 0 && cyc != last_fire_cyc + 1) rec_gaps++;
                        last_fire_cyc = cyc;
                        rec_n++;
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_mode));
                stall_prev = out_valid && !out_ready;
                prev_data  = out_data;
                prev_par   = out_par;
            end
        end
    end

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] m,
                        output int waits);
        bit done;
        done     = 0;
        waits    = 0;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                break;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL send_timeout actual=in_ready_low required=accept_within_60");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Single beat into an empty pipe with literal expectations and latency check.
    task automatic lit(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [1:0] m, input logic [DW-1:0] ed, input logic [L-1:0] ep);
        int w;
        send(a, b, m, w);
        @(negedge clk);
        chk({name, "_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, 64'(out_data), 64'(ed));
        chk({name, "_par"}, 64'(out_par), 64'(ep));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int tot_w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 2'd0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        lit("xor_lit", 32'hFF00A53C, 32'h0F0F5A3C, 2'd0, 32'hF00FFF00, 4'b0000);
        lit("xor_sweep", 32'hCCCCCCCC, 32'hAAAAAAAA, 2'd0, 32'h66666666, 4'b0000);
        lit("xnor_sweep", 32'hCCCCCCCC, 32'hAAAAAAAA, 2'd1, 32'h99999999, 4'b0000);
        lit("parity_lit", 32'h01030700, 32'h00000000, 2'd2, 32'h01000100, 4'b1010);
        lit("bypass_lit", 32'h12345678, 32'hFFFFFFFF, 2'd3, 32'h12345678, 4'b0100);

        // Ten back-to-back beats, modes cycling.
        rec_en   = 1;
        rec_n    = 0;
        rec_gaps = 0;
        tot_w    = 0;
        for (int i = 0; i < 10; i++) begin
            send(DW'($urandom), DW'($urandom), 2'(i % 4), w);
            tot_w += w;
        end
        drain("b2b_drain");
        chk("b2b_in_ready_waits", 64'(tot_w), 64'd0);
        chk("b2b_count", 64'(rec_n), 64'd10);
        chk("b2b_gaps", 64'(rec_gaps), 64'd0);
        rec_en = 0;

        // Backpressure: two beats fill the pipe, the third must stall.
        out_ready = 1'b0;
        send(32'h11223344, 32'h0F0F0F0F, 2'd0, w);
        send(32'hA5A5A5A5, 32'h5A5A5A5A, 2'd1, w);
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h00FF00FF;
        in_mode  = 2'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'hDEADBEEF, 32'h00FF00FF, 2'd2, w);
        drain("bp_drain");

        // Reset with two beats in flight.
        send(32'h01020304, 32'h10203040, 2'd0, w);
        send(32'h55667788, 32'h00000000, 2'd3, w);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
            chk("post_rst_op_cnt", 64'(op_cnt), 64'd0);
        end
        @(posedge clk);
        #1;

        // Mixed traffic with random valid and backpressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a      = DW'($urandom);
            in_b      = DW'($urandom);
            in_mode   = 2'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");

`ifdef XOR_LANE_PIPE_STATS_EN
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_a    = DW'(i);
            in_b    = DW'($urandom);
            in_mode = 2'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain("stats_drain");
        @(negedge clk);
        chk("stats_saturated", 64'(op_cnt), 64'hFFFF);
`else
        @(negedge clk);
        chk("no_stats_op_cnt", 64'(op_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
